sub_seq_int64: RTL and testbench

SUB_SEQ_INT64 -- requirements
Module: sub_seq_int64

---
 rtl/sub_seq_int64.sv | 153 +++++++++++++++
 tb/tb_sub_seq_int64.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_seq_int64.sv
`default_nettype none
// ============================================================================
// Module      : sub_seq_int64
// Description : Multi-cycle WIDTH-bit subtractor. The operands are latched on
//               accept, then CHUNK bits are subtracted per cycle, LSB chunk
//               first, with the borrow rippling between cycles. The result
//               and final borrow are held with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_seq_int64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sub,
    output logic             borrow_out,
    output logic             busy
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_KW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

    localparam logic [c_KW-1:0] c_LAST_K = c_KW'(c_NCHUNK - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Reject parameter sets that would leave a partial chunk.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("sub_seq_int64: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [c_KW-1:0]  r_k;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sub;
    logic             r_borrow_out;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_base;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [CHUNK-1:0] w_a_k;
    logic [CHUNK-1:0] w_b_k;
    logic [CHUNK:0]   w_diff;
    logic [CHUNK-1:0] w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_next;

    assign in_ready   = (r_state == c_IDLE);
    assign out_valid  = (r_state == c_DONE);
    assign busy       = (r_state != c_IDLE);
    assign Sub        = r_sub;
    assign borrow_out = r_borrow_out;

    assign w_accept = in_valid && (r_state == c_IDLE);
    assign w_last   = (r_k == c_LAST_K);

    // Select chunk k of both latched operands.
    assign w_base = 32'(r_k) * 32'(CHUNK);
    assign w_a_sh = r_a >> w_base;
    assign w_b_sh = r_b >> w_base;
    assign w_a_k  = w_a_sh[CHUNK-1:0];
    assign w_b_k  = w_b_sh[CHUNK-1:0];

    // One extra bit on the left catches the borrow out of this chunk.
    assign w_diff  = {1'b0, w_a_k} - {1'b0, w_b_k} - {{CHUNK{1'b0}}, r_borrow};
    assign w_d     = w_diff[CHUNK-1:0];
    assign w_bnext = w_diff[CHUNK];

    // Working result with the current chunk's difference merged in.
    always_comb begin
        w_res_next                    = r_res;
        w_res_next[w_base +: CHUNK]   = w_d;
    end

    // Control FSM: IDLE -> RUN (NCHUNK edges) -> DONE -> IDLE on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_k     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_RUN;
                        r_k     <= '0;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_state <= c_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_k     <= '0;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, ripple one chunk per RUN edge and
    // publish the finished result only on the final chunk so Sub never shows
    // a partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_sub        <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= A;
                r_b      <= B;
                r_res    <= '0;
                r_borrow <= 1'b0;
            end else if (r_state == c_RUN) begin
                r_res    <= w_res_next;
                r_borrow <= w_bnext;
                if (w_last) begin
                    r_sub        <= w_res_next;
                    r_borrow_out <= w_bnext;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_seq_int64.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_seq_int64
// Description : Directed self-checking bench for sub_seq_int64, covering the
//               default 16-bit chunk build and a single-chunk (CHUNK=64) build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_seq_int64;

    logic        clk;
    logic        rst_n;

    // Default build (CHUNK = 16)
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] Sub;
    logic        borrow_out;
    logic        busy;

    // Single-chunk build (CHUNK = 64)
    logic        in_valid2;
    logic        in_ready2;
    logic [63:0] A2;
    logic [63:0] B2;
    logic        out_valid2;
    logic        out_ready2;
    logic [63:0] Sub2;
    logic        borrow_out2;
    logic        busy2;

    int n_checks;
    int n_fail;

    sub_seq_int64 #(.WIDTH(64), .CHUNK(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Sub        (Sub),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    sub_seq_int64 #(.WIDTH(64), .CHUNK(64)) u_dut_c64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .A          (A2),
        .B          (B2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .Sub        (Sub2),
        .borrow_out (borrow_out2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp_v);
        end
    endtask

    // Run one operation on the default build; optionally stall the consumer.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_s, input logic exp_b,
                         input int stall);
        int cyc;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        check("accept_busy", {63'd0, busy}, 64'd1);
        in_valid = 1'b0;
        A        = 64'hDEAD_BEEF_0BAD_F00D;
        B        = 64'h0123_4567_89AB_CDEF;
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'd4);
        check("sub", Sub, exp_s);
        check("borrow", {63'd0, borrow_out}, {63'd0, exp_b});
        for (int i = 0; i < stall; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            A        = 64'd0;
            B        = 64'd1;
            @(posedge clk); #1;
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_ready", {63'd0, in_ready}, 64'd0);
            check("stall_sub", Sub, exp_s);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_ready", {63'd0, in_ready}, 64'd1);
        check("idle_sub", Sub, exp_s);
    endtask

    initial begin
        int cyc;
        int acc_edges[$];
        logic acc;

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        A          = '0;
        B          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        A2         = '0;
        B2         = '0;

        // Reset state
        #3;
        check("rst_ready", {63'd0, in_ready}, 64'd1);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_sub", Sub, 64'd0);
        check("rst_borrow", {63'd0, borrow_out}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Borrow out of every chunk
        do_op(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        // Borrow ripples through chunks 0-2 and is absorbed in chunk 3
        do_op(64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 0);
        // Consumer stalls for three cycles in DONE
        do_op(64'h8000_0000_0000_0005, 64'd3, 64'h8000_0000_0000_0002, 1'b0, 3);
        // Mixed chunks, one internal borrow
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              64'h0246_8ACF_1357_9BCF, 1'b0, 0);
        // Equal operands
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0);
        // Small minus all-ones
        do_op(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 1'b1, 0);

        // Reset during RUN while chunk 2 is being processed
        A        = 64'd100;
        B        = 64'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        check("abort_sub", Sub, 64'd0);
        check("abort_borrow", {63'd0, borrow_out}, 64'd0);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        check("abort_no_result", 64'(cyc), 64'd0);
        rst_n = 1'b1;
        do_op(64'd10, 64'd7, 64'd3, 1'b0, 0);

        // Single-chunk build with in_valid held high: accepts every 3 edges
        A2        = 64'd5;
        B2        = 64'd9;
        in_valid2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc = in_ready2 && in_valid2;
            @(posedge clk); #1;
            if (acc) acc_edges.push_back(i);
            if (out_valid2) begin
                check("c64_latency", 64'(i - acc_edges[acc_edges.size()-1]), 64'd1);
                check("c64_sub", Sub2, 64'hFFFF_FFFF_FFFF_FFFC);
                check("c64_borrow", {63'd0, borrow_out2}, 64'd1);
            end
        end
        in_valid2 = 1'b0;
        check("c64_accepts", 64'(acc_edges.size()), 64'd4);
        for (int i = 1; i < acc_edges.size(); i++) begin
            check("c64_gap", 64'(acc_edges[i] - acc_edges[i-1]), 64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
